// File: rtl/gpu_div_pkg.sv
// Shared widths, latency default, saturation constants and the result record
// used by the divider job sequencer.
package gpu_div_pkg;

  localparam int DIV_NUM_W           = 32;
  localparam int DIV_DEN_W           = 22;
  localparam int DIV_Q_W             = 20;
  localparam int DIV_TAG_W           = 4;
  localparam int DIV_LATENCY_DEFAULT = 5;

  localparam logic [DIV_Q_W-1:0] DIV_Q_POS_SAT = 20'h7FFFF;
  localparam logic [DIV_Q_W-1:0] DIV_Q_NEG_SAT = 20'h80000;

  typedef struct packed {
    logic [DIV_Q_W-1:0]   quot;
    logic [DIV_TAG_W-1:0] tag;
    logic                 divzero;
  } div_result_t;

endpackage

// File: rtl/div_result_fifo.sv
// Synchronous show-ahead FIFO; rdata shows the head entry whenever empty=0.
module div_result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/div_job_sequencer.sv
// Issues tagged jobs to the fixed-latency divider, tracks them alongside it and
// returns quotients in order through a credit-protected result FIFO.
import gpu_div_pkg::*;

module div_job_sequencer #(
  parameter int LATENCY = DIV_LATENCY_DEFAULT,
  parameter int TAG_W   = 4,
  parameter int DEPTH   = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [DIV_NUM_W-1:0] req_num,
  input  logic [DIV_DEN_W-1:0] req_den,
  input  logic [TAG_W-1:0]     req_tag,
  output logic [DIV_NUM_W-1:0] div_numerator,
  output logic [DIV_DEN_W-1:0] div_denominator,
  input  logic [DIV_Q_W-1:0]   div_quotient,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [DIV_Q_W-1:0]   res_quot,
  output logic [TAG_W-1:0]     res_tag,
  output logic                 res_divzero,
  output logic                 busy
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  // Issue register plus LATENCY shifts: the last entry lines up with the cycle
  // in which div_quotient is valid for that job.
  localparam int STAGES = LATENCY + 1;

  logic [CNT_W-1:0]     outstanding_q, outstanding_d;
  logic [DIV_NUM_W-1:0] num_q;
  logic [DIV_DEN_W-1:0] den_q;
  logic [STAGES-1:0]    pv_q, pdz_q, pneg_q;
  logic [TAG_W-1:0]     ptag_q [STAGES];
  logic                 accept, pop, fifo_full, fifo_empty;
  div_result_t          wr_data, head;

  assign req_ready       = (outstanding_q < CNT_W'(DEPTH));
  assign accept          = req_valid && req_ready;
  assign res_valid       = !fifo_empty;
  assign pop             = res_valid && res_ready;
  assign busy            = (outstanding_q != '0);
  assign div_numerator   = num_q;
  assign div_denominator = den_q;

  always_comb begin
    outstanding_d = outstanding_q;
    case ({accept, pop})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      outstanding_q <= '0;
      num_q         <= '0;
      den_q         <= DIV_DEN_W'(1);
      pv_q          <= '0;
      pdz_q         <= '0;
      pneg_q        <= '0;
      for (int unsigned i = 0; i < STAGES; i++) ptag_q[i] <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      num_q         <= accept ? req_num : '0;
      den_q         <= (accept && (req_den != '0)) ? req_den : DIV_DEN_W'(1);
      pv_q          <= {pv_q[STAGES-2:0], accept};
      pdz_q         <= {pdz_q[STAGES-2:0], (req_den == '0)};
      pneg_q        <= {pneg_q[STAGES-2:0], req_num[DIV_NUM_W-1]};
      ptag_q[0]     <= req_tag;
      for (int unsigned i = 1; i < STAGES; i++) ptag_q[i] <= ptag_q[i-1];
    end
  end

  always_comb begin
    wr_data         = '0;
    wr_data.tag     = DIV_TAG_W'(ptag_q[STAGES-1]);
    wr_data.divzero = pdz_q[STAGES-1];
    if (pdz_q[STAGES-1])
      wr_data.quot = pneg_q[STAGES-1] ? DIV_Q_NEG_SAT : DIV_Q_POS_SAT;
    else
      wr_data.quot = div_quotient;
  end

  div_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(div_result_t))
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (pv_q[STAGES-1]),
    .wdata (wr_data),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign res_quot    = res_valid ? head.quot : '0;
  assign res_tag     = res_valid ? TAG_W'(head.tag) : '0;
  assign res_divzero = res_valid && head.divzero;

endmodule

// File: tb/tb_div_job_sequencer.sv
// Directed bench for div_job_sequencer with a behavioural divider and an
// in-order result scoreboard checked every cycle.
module tb_div_job_sequencer;

  localparam int LAT = 5;
  localparam int DEP = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_num;
  logic [21:0] req_den;
  logic [3:0]  req_tag;
  logic [31:0] div_numerator;
  logic [21:0] div_denominator;
  logic [19:0] div_quotient;
  logic        res_valid, res_ready;
  logic [19:0] res_quot;
  logic [3:0]  res_tag;
  logic        res_divzero;
  logic        busy;

  int nchk = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  div_job_sequencer #(.LATENCY(LAT), .TAG_W(4), .DEPTH(DEP)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_num(req_num), .req_den(req_den), .req_tag(req_tag),
    .div_numerator(div_numerator), .div_denominator(div_denominator),
    .div_quotient(div_quotient),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_quot(res_quot), .res_tag(res_tag), .res_divzero(res_divzero),
    .busy(busy)
  );

  // Expected result of a job straight from the arithmetic rules.
  function automatic logic [19:0] ref_q(logic [31:0] n, logic [21:0] d);
    longint ln, ld, q;
    if (d == 22'd0) return n[31] ? 20'h80000 : 20'h7FFFF;
    ln = longint'($signed(n));
    ld = longint'($signed(d));
    q  = ln / ld;
    return q[19:0];
  endfunction

  task automatic chk(string nm, longint unsigned act, longint unsigned exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Divider: quotient of the operands captured LAT edges earlier.
  logic [19:0] dq [LAT];
  initial for (int i = 0; i < LAT; i++) dq[i] = '0;
  always @(posedge clock) begin
    dq[0] <= ref_q(div_numerator, div_denominator);
    for (int i = 1; i < LAT; i++) dq[i] <= dq[i-1];
  end
  assign div_quotient = dq[LAT-1];

  typedef struct packed {
    logic [19:0] q;
    logic [3:0]  t;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   out_m = 0;
  bit   armed = 1'b0;

  always @(negedge clock) begin
    if (armed) begin
      chk("req_ready", req_ready, (out_m < DEP));
      chk("busy", busy, (out_m != 0));
      chk("fifo_write_when_full", dut.u_fifo.push && dut.u_fifo.full, 0);
      if (res_valid) begin
        chk("res_valid_has_pending", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          chk("res_quot", res_quot, sb[0].q);
          chk("res_tag", res_tag, sb[0].t);
          chk("res_divzero", res_divzero, sb[0].dz);
        end
      end
    end
    if (reset) begin
      sb.delete();
      out_m <= 0;
      armed <= 1'b1;
    end else if (armed) begin
      if (req_valid && req_ready)
        sb.push_back('{q: ref_q(req_num, req_den), t: req_tag, dz: (req_den == 22'd0)});
      if (res_valid && res_ready && sb.size() != 0) void'(sb.pop_front());
      out_m <= out_m + int'(req_valid && req_ready) - int'(res_valid && res_ready);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(int num, int den, int tag, output bit acc);
    req_valid = 1'b1;
    req_num   = 32'(num);
    req_den   = 22'(den);
    req_tag   = 4'(tag);
    acc       = req_ready;
    step();
  endtask

  task automatic wait_res();
    int n = 0;
    while (!res_valid && n < 60) begin
      step();
      n++;
    end
    chk("wait_res_timeout", res_valid, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    chk("wait_idle_timeout", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n, cnt, both;
    reset = 1'b1; req_valid = 1'b0; res_ready = 1'b1;
    req_num = '0; req_den = '0; req_tag = '0;
    step(); step();
    reset = 1'b0;
    chk("rst_div_num", div_numerator, 0);
    chk("rst_div_den", div_denominator, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_quot", res_quot, 0);
    chk("rst_res_tag", res_tag, 0);
    chk("rst_res_divzero", res_divzero, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 1);

    // Single job and its latency
    issue(1000, 7, 3, acc);
    req_valid = 1'b0;
    chk("single_accept", acc, 1);
    n = 0;
    while (!res_valid && n < 60) begin
      step();
      n++;
    end
    chk("single_latency", n, LAT + 1);
    chk("single_quot", res_quot, 20'd142);
    chk("single_tag", res_tag, 3);
    chk("single_dz", res_divzero, 0);
    step();
    chk("single_busy_after_pop", busy, 0);
    chk("single_valid_after_pop", res_valid, 0);

    // Negative numerator truncates toward zero
    issue(-1000, 7, 5, acc);
    req_valid = 1'b0;
    wait_res();
    chk("neg_quot", res_quot, 20'hFFF72);
    chk("neg_tag", res_tag, 5);
    chk("neg_dz", res_divzero, 0);
    step();

    // Divide by zero, both signs
    issue(500, 0, 1, acc);
    chk("dz0_div_den", div_denominator, 1);
    chk("dz0_div_num", div_numerator, 500);
    issue(-500, 0, 2, acc);
    req_valid = 1'b0;
    chk("dz1_div_den", div_denominator, 1);
    chk("dz1_div_num", div_numerator, 32'hFFFFFE0C);
    wait_res();
    chk("dz0_quot", res_quot, 20'h7FFFF);
    chk("dz0_tag", res_tag, 1);
    chk("dz0_flag", res_divzero, 1);
    step();
    wait_res();
    chk("dz1_quot", res_quot, 20'h80000);
    chk("dz1_tag", res_tag, 2);
    chk("dz1_flag", res_divzero, 1);
    step();
    wait_idle();

    // Back-pressure: only DEPTH credits
    res_ready = 1'b0;
    cnt = 0;
    for (int t = 0; t < 10; t++) begin
      issue(1000 + t * 37, 3 + t, t, acc);
      cnt += int'(acc);
    end
    req_valid = 1'b0;
    chk("bp_accepted", cnt, 8);
    chk("bp_req_ready_low", req_ready, 0);
    res_ready = 1'b1;
    for (int t = 8; t < 10; t++) begin
      n = 0;
      acc = 1'b0;
      while (!acc && n < 40) begin
        issue(1000 + t * 37, 3 + t, t, acc);
        n++;
      end
      chk("bp_late_accept", acc, 1);
    end
    req_valid = 1'b0;
    wait_idle();

    // Sustained traffic near full credit
    res_ready = 1'b0;
    for (int t = 0; t < DEP; t++) issue(-77 * t - 3, 5, t, acc);
    req_valid = 1'b0;
    repeat (LAT + 3) step();
    chk("ss_fifo_full_valid", res_valid, 1);
    res_ready = 1'b1;
    cnt = 0; both = 0; n = 0;
    while (cnt < 50 && n < 300) begin
      bit popnow;
      int den;
      popnow = res_valid && res_ready;
      den = ($urandom_range(0, 7) == 0) ? 0 : (int'($urandom) >>> 10);
      issue(int'($urandom), den, int'($urandom_range(0, 15)), acc);
      if (acc) cnt++;
      if (acc && popnow) both++;
      n++;
    end
    req_valid = 1'b0;
    chk("ss_accepted", cnt, 50);
    chk("ss_simultaneous", (both >= 45), 1);
    wait_idle();

    // Reset in flight
    for (int t = 0; t < 3; t++) issue(900 + t, 11, 12 + t, acc);
    req_valid = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rr_req_ready", req_ready, 1);
    chk("rr_busy", busy, 0);
    chk("rr_div_den", div_denominator, 1);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cnt += int'(res_valid);
      step();
    end
    chk("rr_no_res_valid", cnt, 0);
    issue(77777, -13, 9, acc);
    req_valid = 1'b0;
    chk("rr_accept", acc, 1);
    wait_res();
    chk("rr_quot", res_quot, 20'hFE8A2);
    chk("rr_tag", res_tag, 9);
    chk("rr_dz", res_divzero, 0);
    step();
    wait_idle();
    step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/div_job_sequencer.md
Name: div_job_sequencer

Overview:
- Initiator and collector for the GPU's fixed-latency pipelined signed divider (32-bit numerator, 22-bit denominator, 20-bit quotient).
- Accepts tagged divide jobs from setup logic over a valid/ready handshake and drives the divider operand ports, at most one job per clock.
- Tracks each job through the divider latency, captures the quotient, and returns it in order with its tag through a result FIFO with valid/ready back-pressure.
- Guarantees no quotient is dropped.

Parameters:
- LATENCY, 5: rising edges from operands presented on div_numerator/div_denominator to the matching div_quotient being valid.
- TAG_W, 4: job tag width.
- DEPTH, 8: result FIFO depth and maximum outstanding jobs; power of 2, at least 2.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  job request.
- req_ready  out  1  job accepted when req_valid and req_ready are both high.
- req_num  in  32  signed numerator.
- req_den  in  22  signed denominator.
- req_tag  in  TAG_W  job tag.
- div_numerator  out  32  registered operand to divider.
- div_denominator  out  22  registered operand to divider.
- div_quotient  in  20  divider result, low 20 bits of the truncated-toward-zero quotient.
- res_valid  out  1  FIFO head valid.
- res_ready  in  1  consumer pop; a pop occurs when res_valid and res_ready are both high.
- res_quot  out  20  quotient.
- res_tag  out  TAG_W  tag of the job.
- res_divzero  out  1  job had req_den == 0.
- busy  out  1  outstanding != 0.

Behaviour:
- Reset values:
  - div_numerator=0, div_denominator=1.
  - res_valid=0, res_quot=0, res_tag=0, res_divzero=0.
  - busy=0, req_ready=1 on the first cycle after reset.
  - Internal state cleared: outstanding counter, valid/tag/divzero tracking pipe, FIFO pointers.
- Credit counter:
  - outstanding counts jobs accepted and not yet popped; range 0..DEPTH.
  - req_ready = (outstanding < DEPTH), combinational from the counter only.
  - Accept alone: +1. Pop alone: -1. Accept and pop in the same cycle: unchanged.
- Issue stage:
  - On accept at edge k, div_numerator <= req_num.
  - div_denominator <= (req_den==0 ? 1 : req_den), so the divider never sees zero.
  - Tracking pipe stage 0 <= {1, req_tag, req_den==0}.
  - With no accept: operands <= 0/1 (bubble), stage-0 valid <= 0.
- Tracking pipe:
  - LATENCY stages of {valid, tag, dz}, shifting every cycle unconditionally; there is no stall because credits guarantee FIFO space.
  - When the last stage is valid, the quotient is captured in the cycle after edge k+LATENCY and written to the FIFO at edge k+LATENCY+1.
- Divide by zero:
  - Written quotient = 20'h7FFFF if the job's numerator is >= 0, else 20'h80000; res_divzero=1.
  - Numerator sign bit travels in the pipe alongside the tag.
- Otherwise the quotient is stored unmodified: no saturation, and the upper quotient bits are discarded by the divider.
- Minimum accept-to-res_valid latency is LATENCY+1 edges. Results leave in acceptance order.
- FIFO:
  - Show-ahead; res_* reflect the head while res_valid=1.
  - res_quot/res_tag/res_divzero are held stable while res_valid=1 and res_ready=0.
  - Simultaneous write and pop when full or empty is legal.
  - Write into an empty FIFO makes res_valid=1 the next cycle.
  - Pointers wrap modulo DEPTH.
- Overflow is impossible by construction. The bench asserts that a FIFO write never occurs when the FIFO is full.
- Reset mid-operation: every tracking stage, the FIFO and the counter are cleared. Quotients still emerging from the divider are ignored because their tracking valid bit is gone.
- req_* are sampled only on accept. If req_valid is dropped without acceptance, nothing is issued.

Decomposition:
- Package gpu_div_pkg holds:
  - DIV_NUM_W=32, DIV_DEN_W=22, DIV_Q_W=20.
  - DIV_LATENCY_DEFAULT=5.
  - Saturation constants DIV_Q_POS_SAT=20'h7FFFF and DIV_Q_NEG_SAT=20'h80000.
  - A packed result struct {quot, tag, divzero}.
- One sub-module: div_result_fifo, a synchronous show-ahead FIFO with parameters DEPTH and width and ports push/pop/full/empty.

Test Plan:
- Bench uses a behavioural divider model of latency LATENCY.
- Single job num=1000, den=7, tag=3, res_ready=1 -> res_valid rises LATENCY+1 edges after accept; res_quot=142, res_tag=3, res_divzero=0; busy falls the cycle after the pop.
- Negative job num=-1000, den=7, tag=5 -> res_quot=20'hFFF72 (-142, truncation toward zero), res_divzero=0.
- Divide by zero, num=500 den=0 tag=1 then num=-500 den=0 tag=2 -> results 20'h7FFFF/dz=1/tag 1, then 20'h80000/dz=1/tag 2; div_denominator observed as 1 on both issue cycles.
- Back-pressure: res_ready=0, 10 back-to-back requests with tags 0..9 -> exactly 8 accepted, req_ready=0 after the 8th; then res_ready=1 -> tags 0..7 pop in order with correct quotients; 9 and 10 are accepted as credits free.
- Steady state at full: outstanding=DEPTH, accept and pop in the same cycle -> outstanding unchanged, no lost or duplicated tag over 50 random jobs checked against the reference model.
- Reset asserted 2 cycles after accepting 3 jobs -> no res_valid afterwards; outstanding=0, req_ready=1, div_denominator=1 next cycle; a new job after reset returns a correct quotient with its own tag.
